// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - seven-segment pattern constants, BCD codes and scan FSM states
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_INVALID = 4'hE;

    typedef enum logic [1:0] {
        SCAN_WAIT,
        SCAN_SETTLE,
        SCAN_HELD
    } scanState_t;

    // Strobe buses are at most 8 digits wide; callers zero-extend.
    function automatic logic isOneHot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/sevenseg_to_bcd.sv
// rtl/sevenseg_to_bcd.sv - combinational abcdefg pattern to BCD decoder
module sevenseg_to_bcd
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       invalid
);

    always_comb begin
        bcd     = BCD_INVALID;
        invalid = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_capture.sv
// rtl/sevenseg_scan_capture.sv - debounces a multiplexed seven-segment bus and assembles BCD frames
module sevenseg_scan_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    frame_error,
    output logic                    frame_timeout
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_SAT   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [6:0]              seg1, seg2;
    logic [NUM_DIGITS-1:0]   sel1, sel2;
    logic [CNT_W-1:0]        settleCnt, timeoutCnt;
    scanState_t              state, stateNext;
    logic                    changing, nextOneHot, capture, frameDone, timeoutHit;
    logic [3:0]              decBcd;
    logic                    decInvalid;
    logic [NUM_DIGITS-1:0]   mask, errBits, maskNext, errNext;
    logic [4*NUM_DIGITS-1:0] shadow, shadowNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg1 <= '0;
            seg2 <= '0;
            sel1 <= '0;
            sel2 <= '0;
        end else begin
            seg1 <= seg_in;
            seg2 <= seg1;
            sel1 <= digit_sel;
            sel2 <= sel1;
        end
    end

    // Looking one stage ahead lets the counter read 0 on the first cycle s2 shows a new value.
    assign changing   = (seg1 != seg2) || (sel1 != sel2);
    assign nextOneHot = isOneHot(8'(sel1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settleCnt <= '0;
        end else if (changing) begin
            settleCnt <= '0;
        end else if (settleCnt != SETTLE_SAT) begin
            settleCnt <= settleCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCAN_WAIT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (changing) begin
            stateNext = nextOneHot ? SCAN_SETTLE : SCAN_WAIT;
        end else if (capture) begin
            stateNext = SCAN_HELD;
        end
    end

    always_comb begin
        capture = (state == SCAN_SETTLE) && (settleCnt == SETTLE_LAST);
    end

    sevenseg_to_bcd u_decode (
        .seg     (seg2),
        .bcd     (decBcd),
        .invalid (decInvalid)
    );

    always_comb begin
        shadowNext = shadow;
        errNext    = errBits;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel2[i]) begin
                shadowNext[4*i +: 4] = decBcd;
                errNext[i]           = decInvalid;
            end
        end
        maskNext = mask | sel2;
    end

    assign frameDone  = capture && (&maskNext);
    assign timeoutHit = !capture && (mask != '0) && (timeoutCnt == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out       <= '0;
            frame_valid   <= 1'b0;
            frame_error   <= 1'b0;
            frame_timeout <= 1'b0;
            mask          <= '0;
            errBits       <= '0;
            shadow        <= '0;
            timeoutCnt    <= '0;
        end else begin
            frame_valid   <= 1'b0;
            frame_error   <= 1'b0;
            frame_timeout <= 1'b0;
            if (capture) begin
                timeoutCnt <= '0;
                shadow     <= shadowNext;
                if (frameDone) begin
                    bcd_out     <= shadowNext;
                    frame_valid <= 1'b1;
                    frame_error <= |errNext;
                    mask        <= '0;
                    errBits     <= '0;
                end else begin
                    mask    <= maskNext;
                    errBits <= errNext;
                end
            end else if (timeoutHit) begin
                mask          <= '0;
                errBits       <= '0;
                timeoutCnt    <= '0;
                frame_timeout <= 1'b1;
            end else if (mask == '0) begin
                timeoutCnt <= '0;
            end else begin
                timeoutCnt <= timeoutCnt + CNT_W'(1);
            end
        end
    end

endmodule
